stall_response_ctrl: RTL
========================

Name: stall_response_ctrl

Overview:
Pipeline-control responder for the load-use stall request produced by the ID-stage hazard detector.
- Converts `stall_req` and `branch_taken` into PC / IF-ID write enables, an IF-ID flush and an ID-EX bubble.
- Owns the ID-EX hazard-tracking register (`ex_td`, `ex_LW`) that feeds back into the detector's `id_td` / `id_LW` inputs.
- Supports multi-cycle load stalls for slow data memory through a small state machine.

Parameters:
- `LOAD_STALL_CYCLES`, 1: bubbles inserted per load-use hazard; legal range 1..15.
- `CNT_W`, 4: width of the internal stall down-counter.

Ports:
- `clk` — input, 1 — system clock; all state updates on its rising edge.
- `rst` — input, 1 — synchronous, active-high reset.
- `stall_req` — input, 1 — load-use hazard request from the ID-stage detector.
- `branch_taken` — input, 1 — branch/jump resolved taken in ID this cycle.
- `id_load` — input, 1 — instruction currently in ID is a load (lw).
- `id_rd` — input, 5 — destination register of the instruction in ID (0 if none).
- `pc_we` — output, 1 — PC write enable.
- `ifid_we` — output, 1 — IF/ID pipeline register write enable.
- `ifid_flush` — output, 1 — clear IF/ID to NOP on the next edge.
- `idex_bubble` — output, 1 — load NOP control into ID/EX on the next edge.
- `ex_td` — output, 5 — registered destination register of the instruction in EX.
- `ex_LW` — output, 1 — registered flag: the instruction in EX is a load.
- `stalling` — output, 1 — state is STALL (debug/visibility).

Behaviour:
- States:
  - RUN (reset state).
  - STALL: extra bubbles pending, only reachable when `LOAD_STALL_CYCLES` > 1.
- Outputs `pc_we`, `ifid_we`, `ifid_flush` and `idex_bubble` are combinational from state and inputs.
- While `rst` = 1:
  - `pc_we` = 0, `ifid_we` = 0, `ifid_flush` = 0, `idex_bubble` = 1.
  - On the edge: state <= RUN, counter <= 0, `ex_td` <= 0, `ex_LW` <= 0.
  - After release, `stalling` = 0.
- RUN, `stall_req` = 1:
  - `pc_we` = 0, `ifid_we` = 0, `idex_bubble` = 1, `ifid_flush` = 0.
  - If `LOAD_STALL_CYCLES` > 1: next state STALL, counter <= `LOAD_STALL_CYCLES` - 2.
- RUN, `stall_req` = 0:
  - `pc_we` = 1, `ifid_we` = 1, `idex_bubble` = 0, `ifid_flush` = `branch_taken`.
- STALL:
  - `pc_we` = 0, `ifid_we` = 0, `idex_bubble` = 1, `ifid_flush` = 0, regardless of inputs.
  - If counter == 0, go to RUN; else decrement.
  - `stall_req`/`branch_taken` are ignored in STALL; they are re-evaluated in RUN once the load has advanced.
- Simultaneous `stall_req` and `branch_taken` in RUN: stall wins and no flush occurs. The branch stays in ID and re-resolves after the stall.
- ID-EX tracking register, every edge without reset:
  - If `idex_bubble`: `ex_LW` <= 0, `ex_td` <= 0.
  - Else: `ex_LW` <= `id_load`, `ex_td` <= `id_rd`.
- The bubble clears `ex_LW`, so the detector naturally drops `stall_req` the cycle after a single-cycle stall. No combinational loop exists: `stall_req` depends only on registered `ex_*` plus ID fields.
- Total hazard penalty is exactly `LOAD_STALL_CYCLES` cycles with `pc_we` = 0.
- Reset asserted mid-STALL: abort immediately; state RUN after release, no residual bubble.

Optional Feature:
- Macro `STALL_PERF_CNT_EN`.
- Defined:
  - Adds output `stall_cycles` (32-bit): increments every non-reset cycle with `pc_we` = 0, wraps at 2^32.
  - Adds output `flush_count` (32-bit): increments on each `ifid_flush` = 1 cycle.
  - Both counters reset to 0.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - State encoding (ST_RUN = 0, ST_STALL = 1).
  - `REG_IDX_W` = 5.
  - NOP control constants used for the bubble.
  - Default `LOAD_STALL_CYCLES`.
- One sub-module, `idex_hazard_reg`: the clocked `ex_td`/`ex_LW` register with sync reset and bubble clear, reusable by the forwarding unit.

Test Plan:
1. `LOAD_STALL_CYCLES` = 1: cycle 0 `id_load` = 1, `id_rd` = 8; cycle 1 `stall_req` = 1 -> cycle 1: `pc_we` = 0, `idex_bubble` = 1; after edge `ex_LW` = 0, `ex_td` = 0; cycle 2 `stall_req` = 0 -> `pc_we` = 1.
2. `LOAD_STALL_CYCLES` = 3, single `stall_req` pulse -> `pc_we` = 0 for exactly 3 consecutive cycles, `stalling` = 1 in cycles 2–3, then RUN.
3. `stall_req` = 1 and `branch_taken` = 1 same cycle -> `ifid_flush` = 0, `pc_we` = 0; next cycle `branch_taken` = 1 alone -> `ifid_flush` = 1, `pc_we` = 1.
4. Normal flow, `id_load` = 0, `id_rd` = 5 -> after edge `ex_td` = 5, `ex_LW` = 0; with `id_load` = 1, `id_rd` = 9 -> `ex_td` = 9, `ex_LW` = 1.
5. `LOAD_STALL_CYCLES` = 4, assert `rst` in the second STALL cycle -> during `rst` `pc_we` = 0, `idex_bubble` = 1; the cycle after release: RUN, `stalling` = 0, `pc_we` = 1, `ex_*` = 0.
6. With `STALL_PERF_CNT_EN`: 2 hazards at `LOAD_STALL_CYCLES` = 2 plus 3 taken branches -> `stall_cycles` = 4, `flush_count` = 3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, register-index width and NOP controls
// for the load-use stall responder and the ID-EX hazard-tracking register.
package pipe_ctrl_pkg;
   typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;
   localparam int REG_IDX_W = 5;
   localparam int DEF_LOAD_STALL_CYCLES = 1;
   localparam logic [REG_IDX_W-1:0] NOP_TD = '0;
   localparam logic NOP_LW = 1'b0;
endpackage

// File: rtl/idex_hazard_reg.sv
// idex_hazard_reg: ID-EX destination/load tracking register; a bubble or reset
// loads NOP controls so the hazard detector sees no pending load.
import pipe_ctrl_pkg::*;
module idex_hazard_reg (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bubble,
   input  logic                 id_load,
   input  logic [REG_IDX_W-1:0] id_rd,
   output logic [REG_IDX_W-1:0] ex_td,
   output logic                 ex_LW
);
   always_ff @(posedge clk) begin
      ex_td <= (rst || bubble) ? NOP_TD : id_rd;
      ex_LW <= (rst || bubble) ? NOP_LW : id_load;
   end
endmodule

// File: rtl/stall_response_ctrl.sv
// stall_response_ctrl: turns load-use stall requests and taken branches into
// PC/IF-ID enables, IF-ID flush and ID-EX bubble; optional STALL_PERF_CNT_EN.
import pipe_ctrl_pkg::*;
module stall_response_ctrl #(
   parameter int LOAD_STALL_CYCLES = DEF_LOAD_STALL_CYCLES,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_req,
   input  logic                 branch_taken,
   input  logic                 id_load,
   input  logic [REG_IDX_W-1:0] id_rd,
   output logic                 pc_we,
   output logic                 ifid_we,
   output logic                 ifid_flush,
   output logic                 idex_bubble,
   output logic [REG_IDX_W-1:0] ex_td,
   output logic                 ex_LW,
   output logic                 stalling
`ifdef STALL_PERF_CNT_EN
  ,output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_count
`endif
);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (rst) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end else if (state == ST_STALL) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         state_nx    = (cnt == '0) ? ST_RUN : ST_STALL;
         cnt_nx      = (cnt == '0) ? cnt : cnt - 1'b1;
      end else if (stall_req) begin
         // stall beats a simultaneous branch: the branch re-resolves afterwards
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            state_nx = ST_STALL;
            cnt_nx   = CNT_W'(LOAD_STALL_CYCLES - 2);
         end
      end else begin
         ifid_flush = branch_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   assign stalling = (state == ST_STALL);

   idex_hazard_reg u_idex (
      .clk     (clk),
      .rst     (rst),
      .bubble  (idex_bubble),
      .id_load (id_load),
      .id_rd   (id_rd),
      .ex_td   (ex_td),
      .ex_LW   (ex_LW)
   );

`ifdef STALL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         stall_cycles <= stall_cycles + {31'd0, ~pc_we};
         flush_count  <= flush_count + {31'd0, ifid_flush};
      end
   end
`endif
endmodule
